// File: rtl/bp_access_scheduler.sv
// Sole owner of the two-bit-counter predictor table command ports: arbitrates fetch lookups,
// FIFO-buffered training updates and a full-table flush so at most one command issues per cycle.
module bp_access_scheduler #(
  parameter int INDEX_W    = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               lookup_valid,
  input  logic [INDEX_W-1:0] lookup_index,
  output logic               lookup_ready,
  output logic               pred_valid,
  output logic               pred_taken,
  input  logic               upd_valid,
  input  logic [INDEX_W-1:0] upd_index,
  input  logic               upd_taken,
  output logic               upd_ready,
  input  logic               flush_req,
  output logic               flush_busy,
  output logic               tbl_get,
  output logic [INDEX_W-1:0] tbl_get_index,
  output logic               tbl_set,
  output logic [INDEX_W-1:0] tbl_set_index,
  output logic               tbl_feedback,
  output logic               tbl_reset,
  output logic [INDEX_W-1:0] tbl_reset_index,
  input  logic               tbl_prediction
);

  localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W    = PTR_W + 1;
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  localparam logic [INDEX_W:0]  FLUSH_END  = {1'b1, {INDEX_W{1'b0}}};
  localparam logic [CNT_W-1:0]  FIFO_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  logic [0:0]          r_state;
  logic                r_live;
  logic [INDEX_W:0]    r_flush_cnt;
  logic [INDEX_W-1:0]  r_fifo_idx [FIFO_DEPTH];
  logic                r_fifo_tkn [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic [STARVE_W-1:0] r_starve;

  logic               r_tbl_get;
  logic [INDEX_W-1:0] r_tbl_get_index;
  logic               r_tbl_set;
  logic [INDEX_W-1:0] r_tbl_set_index;
  logic               r_tbl_feedback;
  logic               r_tbl_reset;
  logic [INDEX_W-1:0] r_tbl_reset_index;
  logic               r_pred_valid;

  logic w_run;
  logic w_empty;
  logic w_full;
  logic w_flush_start;
  logic w_upd_force;
  logic w_lookup_grant;
  logic w_pop;
  logic w_push;

  // r_live keeps both readies low until the first clock edge after reset releases.
  assign w_run          = r_live && (r_state == ST_RUN);
  assign w_empty        = (r_count == '0);
  assign w_full         = (r_count == FIFO_FULL);
  assign w_flush_start  = w_run && flush_req;
  assign w_upd_force    = !w_empty && (w_full || (r_starve == STARVE_LIM));

  assign lookup_ready   = w_run && !flush_req && !w_upd_force;
  assign upd_ready      = w_run && !w_full;
  assign w_lookup_grant = lookup_valid && lookup_ready;
  // Pops only drain entries already stored, so a fresh push never bypasses a lookup.
  assign w_pop          = w_run && !flush_req && !w_empty && !w_lookup_grant;
  // An update accepted alongside flush_req is discarded with the rest of the FIFO.
  assign w_push         = upd_valid && upd_ready && !flush_req;

  assign flush_busy      = (r_state == ST_FLUSH);
  assign pred_valid      = r_pred_valid;
  assign pred_taken      = r_pred_valid & tbl_prediction;
  assign tbl_get         = r_tbl_get;
  assign tbl_get_index   = r_tbl_get_index;
  assign tbl_set         = r_tbl_set;
  assign tbl_set_index   = r_tbl_set_index;
  assign tbl_feedback    = r_tbl_feedback;
  assign tbl_reset       = r_tbl_reset;
  assign tbl_reset_index = r_tbl_reset_index;

  // NOTE: FIFO storage is not reset; pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_idx[r_wr_ptr] <= upd_index;
      r_fifo_tkn[r_wr_ptr] <= upd_taken;
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state           <= ST_RUN;
      r_live            <= 1'b0;
      r_flush_cnt       <= '0;
      r_wr_ptr          <= '0;
      r_rd_ptr          <= '0;
      r_count           <= '0;
      r_starve          <= '0;
      r_tbl_get         <= 1'b0;
      r_tbl_get_index   <= '0;
      r_tbl_set         <= 1'b0;
      r_tbl_set_index   <= '0;
      r_tbl_feedback    <= 1'b0;
      r_tbl_reset       <= 1'b0;
      r_tbl_reset_index <= '0;
      r_pred_valid      <= 1'b0;
    end else begin
      r_live <= 1'b1;

      r_tbl_get       <= w_lookup_grant;
      r_tbl_get_index <= w_lookup_grant ? lookup_index : '0;
      r_tbl_set       <= w_pop;
      r_tbl_set_index <= w_pop ? r_fifo_idx[r_rd_ptr] : '0;
      r_tbl_feedback  <= w_pop ? r_fifo_tkn[r_rd_ptr] : 1'b0;
      r_pred_valid    <= r_tbl_get;

      if (w_flush_start) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end

      if (w_flush_start || w_pop || w_empty) begin
        r_starve <= '0;
      end else if (w_lookup_grant && (r_starve != STARVE_LIM)) begin
        r_starve <= r_starve + STARVE_W'(1);
      end

      // The flush issues index 0 on the cycle it enters FLUSH so tbl_reset tracks flush_busy.
      case (r_state)
        ST_RUN: begin
          if (w_flush_start) begin
            r_state           <= ST_FLUSH;
            r_tbl_reset       <= 1'b1;
            r_tbl_reset_index <= '0;
            r_flush_cnt       <= (INDEX_W+1)'(1);
          end else begin
            r_tbl_reset       <= 1'b0;
            r_tbl_reset_index <= '0;
          end
        end
        ST_FLUSH: begin
          if (r_flush_cnt == FLUSH_END) begin
            r_state           <= ST_RUN;
            r_tbl_reset       <= 1'b0;
            r_tbl_reset_index <= '0;
          end else begin
            r_tbl_reset       <= 1'b1;
            r_tbl_reset_index <= r_flush_cnt[INDEX_W-1:0];
            r_flush_cnt       <= r_flush_cnt + (INDEX_W+1)'(1);
          end
        end
        default: begin
          r_state     <= ST_RUN;
          r_tbl_reset <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bp_access_scheduler.sv
// Randomized scoreboard bench: a queue-based scheduler model predicts readies, table commands
// and predictions; a negedge monitor compares the DUT's table commands and results in order.
module tb_bp_access_scheduler;

  localparam int INDEX_W = 8;
  localparam int DEPTH   = 4;
  localparam int SMAX    = 3;
  localparam int N       = 1 << INDEX_W;

  typedef struct {
    int kind;   // 1 get, 2 set, 3 reset
    int idx;
    int fb;
    int cyc;
  } cmd_t;

  typedef struct {
    int val;
    int cyc;
  } pred_t;

  typedef struct {
    int idx;
    int tkn;
  } upd_t;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               lookup_valid = 1'b0;
  logic [INDEX_W-1:0] lookup_index = '0;
  logic               lookup_ready;
  logic               pred_valid;
  logic               pred_taken;
  logic               upd_valid = 1'b0;
  logic [INDEX_W-1:0] upd_index = '0;
  logic               upd_taken = 1'b0;
  logic               upd_ready;
  logic               flush_req = 1'b0;
  logic               flush_busy;
  logic               tbl_get;
  logic [INDEX_W-1:0] tbl_get_index;
  logic               tbl_set;
  logic [INDEX_W-1:0] tbl_set_index;
  logic               tbl_feedback;
  logic               tbl_reset;
  logic [INDEX_W-1:0] tbl_reset_index;
  logic               tbl_prediction = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit done = 1'b0;

  cmd_t  cmd_q[$];
  pred_t pred_q[$];

  // Reference model state
  bit       m_flush = 1'b0;
  int       m_fcnt = 0;
  upd_t     m_pend[$];
  int       m_starve = 0;
  bit [1:0] m_tbl [N];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  bp_access_scheduler #(.INDEX_W(INDEX_W), .FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .lookup_valid    (lookup_valid),
    .lookup_index    (lookup_index),
    .lookup_ready    (lookup_ready),
    .pred_valid      (pred_valid),
    .pred_taken      (pred_taken),
    .upd_valid       (upd_valid),
    .upd_index       (upd_index),
    .upd_taken       (upd_taken),
    .upd_ready       (upd_ready),
    .flush_req       (flush_req),
    .flush_busy      (flush_busy),
    .tbl_get         (tbl_get),
    .tbl_get_index   (tbl_get_index),
    .tbl_set         (tbl_set),
    .tbl_set_index   (tbl_set_index),
    .tbl_feedback    (tbl_feedback),
    .tbl_reset       (tbl_reset),
    .tbl_reset_index (tbl_reset_index),
    .tbl_prediction  (tbl_prediction)
  );

  function automatic bit [1:0] init_val(input int i);
    return (i == 5) ? 2'd2 : 2'((i * 7 + 3) % 4);
  endfunction

  function automatic bit [1:0] train(input bit [1:0] c, input int taken);
    if (taken != 0) return (c == 2'd3) ? 2'd3 : c + 2'd1;
    return (c == 2'd0) ? 2'd0 : c - 2'd1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Predictor table environment: registered read, saturating training, reset to weakly not-taken.
  initial begin : table_env
    bit [1:0] env_tbl [N];
    for (int i = 0; i < N; i++) env_tbl[i] = init_val(i);
    forever begin
      @(posedge clk);
      if (tbl_get) tbl_prediction <= (env_tbl[tbl_get_index] >= 2'd2);
      else         tbl_prediction <= 1'($urandom);
      if (tbl_set)   env_tbl[tbl_set_index]   <= train(env_tbl[tbl_set_index], int'(tbl_feedback));
      if (tbl_reset) env_tbl[tbl_reset_index] <= 2'd1;
    end
  end

  always @(negedge clk) begin : monitor
    cmd_t  e;
    pred_t p;
    int    kind;
    int    idx;
    if (reset_n && !done) begin
      check("single_cmd", 32'(($countones({tbl_get, tbl_set, tbl_reset}) <= 1)), 32'd1);
      kind = tbl_get ? 1 : tbl_set ? 2 : tbl_reset ? 3 : 0;
      idx  = tbl_get ? int'(tbl_get_index) : tbl_set ? int'(tbl_set_index) : int'(tbl_reset_index);
      if (kind != 0) begin
        if (cmd_q.size() == 0) begin
          check("unexpected_cmd_kind", kind, 0);
        end else begin
          e = cmd_q.pop_front();
          check("cmd_kind", kind, e.kind);
          check("cmd_index", idx, e.idx);
          check("cmd_cycle", cyc, e.cyc);
          if (e.kind == 2) check("set_feedback", 32'(tbl_feedback), e.fb);
        end
      end else if (cmd_q.size() > 0 && cmd_q[0].cyc <= cyc) begin
        e = cmd_q.pop_front();
        check("missing_cmd_kind", 0, e.kind);
      end
      if (pred_valid) begin
        if (pred_q.size() == 0) begin
          check("unexpected_pred_valid", 1, 0);
        end else begin
          p = pred_q.pop_front();
          check("pred_taken", 32'(pred_taken), p.val);
          check("pred_cycle", cyc, p.cyc);
        end
      end else begin
        check("pred_taken_idle", 32'(pred_taken), 0);
        if (pred_q.size() > 0 && pred_q[0].cyc <= cyc) begin
          p = pred_q.pop_front();
          check("missing_pred_valid", 0, 1);
        end
      end
    end
  end

  task automatic push_cmd(input int kind, input int idx, input int fb);
    cmd_q.push_back('{kind: kind, idx: idx, fb: fb, cyc: cyc + 1});
  endtask

  // One clock of stimulus; the model decides readies and the resulting table traffic.
  task automatic drive_cycle(input bit lv, input int li, input bit uv, input int ui,
                             input bit ut, input bit fr);
    bit exp_lr, exp_ur, exp_busy, full, had, took;
    upd_t u;
    @(negedge clk);
    #1;
    lookup_valid = lv;
    lookup_index = li[INDEX_W-1:0];
    upd_valid    = uv;
    upd_index    = ui[INDEX_W-1:0];
    upd_taken    = ut;
    flush_req    = fr;
    #1;
    full = (m_pend.size() == DEPTH);
    had  = (m_pend.size() > 0);
    exp_busy = m_flush;
    if (m_flush) begin
      exp_lr = 1'b0;
      exp_ur = 1'b0;
    end else begin
      exp_ur = !full;
      exp_lr = !fr && !(had && (full || m_starve == SMAX));
    end
    check("lookup_ready", 32'(lookup_ready), 32'(exp_lr));
    check("upd_ready", 32'(upd_ready), 32'(exp_ur));
    check("flush_busy", 32'(flush_busy), 32'(exp_busy));

    if (m_flush) begin
      if (m_fcnt < N) begin
        push_cmd(3, m_fcnt, 0);
        m_tbl[m_fcnt] = 2'd1;
        m_fcnt++;
      end else begin
        m_flush = 1'b0;
      end
    end else if (fr) begin
      m_pend.delete();
      m_starve = 0;
      m_flush  = 1'b1;
      push_cmd(3, 0, 0);
      m_tbl[0] = 2'd1;
      m_fcnt   = 1;
    end else begin
      took = lv && exp_lr;
      if (took) begin
        push_cmd(1, li, 0);
        pred_q.push_back('{val: int'(m_tbl[li] >= 2'd2), cyc: cyc + 2});
        m_starve = had ? ((m_starve < SMAX) ? m_starve + 1 : SMAX) : 0;
      end else if (had) begin
        u = m_pend.pop_front();
        push_cmd(2, u.idx, u.tkn);
        m_tbl[u.idx] = train(m_tbl[u.idx], u.tkn);
        m_starve = 0;
      end else begin
        m_starve = 0;
      end
      if (uv && exp_ur) m_pend.push_back('{idx: ui, tkn: int'(ut)});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    {lookup_valid, upd_valid, upd_taken, flush_req} = '0;
    lookup_index = '0;
    upd_index    = '0;
    cmd_q.delete();
    pred_q.delete();
    m_pend.delete();
    m_starve = 0;
    m_flush  = 1'b0;
    #1;
    check("rst_strobes", 32'({tbl_get, tbl_set, tbl_reset, tbl_feedback, pred_valid, pred_taken,
                              flush_busy, lookup_ready, upd_ready}), 0);
    check("rst_indices", 32'({tbl_get_index, tbl_set_index, tbl_reset_index}), 0);
    repeat (2) @(negedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic fill_to(input int target, input string name);
    int guard = 0;
    while (m_pend.size() != target && guard < 50) begin
      drive_cycle(1'b1, int'($urandom_range(0, N - 1)), 1'b1, int'($urandom_range(0, N - 1)),
                  1'($urandom), 1'b0);
      guard++;
    end
    check(name, m_pend.size(), target);
  endtask

  initial begin
    for (int i = 0; i < N; i++) m_tbl[i] = init_val(i);

    apply_reset();

    // Lookup of an entry holding counter value 2, then a lone taken update to entry 7.
    drive_cycle(1'b1, 5, 1'b0, 0, 1'b0, 1'b0);
    idle(3);
    drive_cycle(1'b0, 0, 1'b1, 7, 1'b1, 1'b0);
    idle(3);

    // Mixed lookups and updates.
    for (int i = 0; i < 300; i++)
      drive_cycle(1'($urandom), int'($urandom_range(0, N - 1)), ($urandom % 10) < 3,
                  int'($urandom_range(0, N - 1)), 1'($urandom), 1'b0);

    // Lookups held high: FIFO fills, starvation and full-FIFO forcing.
    for (int i = 0; i < 40; i++)
      drive_cycle(1'b1, int'($urandom_range(0, N - 1)), 1'b1, int'($urandom_range(0, N - 1)),
                  1'($urandom), 1'b0);
    for (int i = 0; i < 100; i++)
      drive_cycle(1'b1, int'($urandom_range(0, N - 1)), 1'($urandom),
                  int'($urandom_range(0, N - 1)), 1'($urandom), 1'b0);

    // Reset with three queued updates: nothing may be trained afterwards.
    idle(6);
    fill_to(3, "fifo_fill_3");
    apply_reset();
    idle(8);

    // Flush with two updates queued, raised together with a lookup and an update.
    fill_to(2, "fifo_fill_2");
    drive_cycle(1'b1, 9, 1'b1, 11, 1'b1, 1'b1);
    for (int i = 0; i < 262; i++)
      drive_cycle(1'($urandom), int'($urandom_range(0, N - 1)), 1'($urandom),
                  int'($urandom_range(0, N - 1)), 1'($urandom), ($urandom % 20) == 0);
    idle(2);

    // Everything random, occasional flush pulses.
    for (int i = 0; i < 700; i++)
      drive_cycle(1'($urandom), int'($urandom_range(0, N - 1)), ($urandom % 10) < 5,
                  int'($urandom_range(0, N - 1)), 1'($urandom), ($urandom % 300) == 0);

    for (int i = 0; i < 400 && m_flush; i++) idle(1);
    idle(8);
    done = 1'b1;
    check("cmd_queue_drained", cmd_q.size(), 0);
    check("pred_queue_drained", pred_q.size(), 0);
    check("model_fifo_drained", m_pend.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
